dictr_cmd_parser: RTL and testbench
===================================

DICTR_CMD_PARSER -- requirements
Module: dictr_cmd_parser

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, 24'd12_000_000, idle cycles allowed between bytes of a load command (1 s at 12 MHz).
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on posedge clk.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: rx_data  input  8  received ASCII byte from UART receiver.
REQ-005 SHALL have port: rx_data_rdy  input  1  one-cycle strobe; rx_data valid in that cycle only.
REQ-006 SHALL have port: det_S  output  1  one-cycle pulse: start command decoded (feeds clock FSM).
REQ-007 SHALL have port: det_cr  output  1  one-cycle pulse: stop command (CR) decoded (feeds clock FSM).
REQ-008 SHALL have port: ld_valid  output  1  one-cycle pulse: complete, valid load command; ld_* digits valid in same cycle.
REQ-009 SHALL have port: ld_Mtens, ld_Mones, ld_Stens, ld_Sones  output  4 each  BCD load digits.
REQ-010 SHALL have port: parse_err  output  1  one-cycle pulse: load command rejected.
REQ-011 SHALL have port: busy  output  1  high while a load command is in progress.

Function
REQ-012 SHALL be a registered FSM; every output pulse asserts exactly one cycle after the cycle rx_data_rdy sampled the byte.
REQ-013 SHALL implement states IDLE, GET_MT, GET_MO, GET_ST, GET_SO, WAIT_CR.
REQ-014 In IDLE: 'S'/'s' (0x53/0x73) -> det_S pulse, stay IDLE; 0x0D -> det_cr pulse, stay IDLE; 'L'/'l' -> GET_MT; all other bytes ignored.
REQ-015 GET_MT accepts '0'-'5', GET_MO '0'-'9', GET_ST '0'-'5', GET_SO '0'-'9'; an accepted digit stores (byte - 0x30) into the matching internal digit register and advances to the next state (GET_SO -> WAIT_CR).
REQ-016 In WAIT_CR, 0x0D SHALL pulse ld_valid, drive the four stored digits on ld_*, and return to IDLE; det_cr SHALL NOT pulse for this CR.
REQ-017 In any GET_*/WAIT_CR state, an out-of-range digit, non-digit, or CR before WAIT_CR SHALL pulse parse_err and return to IDLE; det_S/det_cr SHALL NOT pulse.
REQ-018 ESC (0x1B) in any non-IDLE state SHALL return to IDLE silently (no pulse); in IDLE it is ignored.
REQ-019 A 24-bit idle counter SHALL clear on every rx_data_rdy and count while busy; reaching TIMEOUT_CYC-1 SHALL pulse parse_err and return to IDLE.
REQ-020 busy SHALL be high exactly in GET_MT..WAIT_CR.
REQ-021 ld_* SHALL hold the last loaded value between ld_valid pulses; partial-command digits SHALL NOT appear on ld_*.
REQ-022 At most one of det_S, det_cr, ld_valid, parse_err SHALL be high in any cycle.
REQ-023 If rx_data_rdy coincides with the timeout cycle, the byte SHALL be processed and the timeout discarded.

Reset
REQ-024 rst SHALL force IDLE, clear idle counter, drive det_S, det_cr, ld_valid, parse_err, busy to 0 and ld_* to 0 on the next clk edge; rst overrides rx_data_rdy in the same cycle.
REQ-025 rst mid-command SHALL discard the partial command with no pulse.

Structure
REQ-026 A shared package dictr_pkg SHALL hold ASCII constants (0x0D, 0x1B, 'S', 's', 'L', 'l', '0') and the parser state encoding.
REQ-027 A sub-module dictr_digit_check SHALL map an ASCII byte plus a max-digit input (5 or 9) to a 4-bit BCD value and an in-range flag; instantiated once.

Verification
REQ-028 Bench SHALL check: byte 's' in IDLE -> det_S high exactly 1 cycle, one cycle after strobe; 0x0D -> det_cr likewise.
REQ-029 Bench SHALL check: "L","1","2","3","4",CR -> ld_valid pulse with ld_Mtens=1, ld_Mones=2, ld_Stens=3, ld_Sones=4; no det_cr; busy low afterwards.
REQ-030 Bench SHALL check: "L","6" -> parse_err pulse one cycle after the '6' strobe, busy low, ld_* unchanged from previous load.
REQ-031 Bench SHALL check: with TIMEOUT_CYC=16, "L","1" then no bytes -> parse_err 16 cycles after the '1' strobe; a following 'S' -> det_S.
REQ-032 Bench SHALL check: "L","0","5",ESC -> no pulses, busy low; rst asserted during GET_ST -> all outputs 0 next cycle, then "S" -> det_S.

Source files
------------

// File: rtl/dictr_pkg.sv
// Shared constants and state encoding for the dictr command parser.
// Holds the ASCII codes it recognises and the maximum digit value for each load field.
package dictr_pkg;

    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_ESC  = 8'h1B;
    localparam logic [7:0] ASCII_S_UP = 8'h53;
    localparam logic [7:0] ASCII_S_LO = 8'h73;
    localparam logic [7:0] ASCII_L_UP = 8'h4C;
    localparam logic [7:0] ASCII_L_LO = 8'h6C;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    localparam logic [3:0] MAX_TENS = 4'd5;
    localparam logic [3:0] MAX_ONES = 4'd9;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_MT  = 3'd1,
        GET_MO  = 3'd2,
        GET_ST  = 3'd3,
        GET_SO  = 3'd4,
        WAIT_CR = 3'd5
    } parser_state_t;

    // Tens fields of minutes/seconds stop at 5; ones fields run to 9.
    function automatic logic [3:0] max_digit_for(input parser_state_t s);
        return (s == GET_MT || s == GET_ST) ? MAX_TENS : MAX_ONES;
    endfunction

endpackage

// File: rtl/dictr_digit_check.sv
// Converts an ASCII byte to BCD and checks that it is a decimal digit
// no greater than max_digit.
module dictr_digit_check
    import dictr_pkg::*;
(
    input  logic [7:0] ascii,
    input  logic [3:0] max_digit,
    output logic [3:0] bcd,
    output logic       in_range
);

    logic [7:0] offset;

    assign offset   = ascii - ASCII_ZERO;
    assign bcd      = offset[3:0];
    assign in_range = (ascii >= ASCII_ZERO) && (offset <= {4'd0, max_digit});

endmodule

// File: rtl/dictr_cmd_parser.sv
// UART command parser: 'S' starts the clock, CR stops it, and "Lmmss<CR>"
// loads a time value; every output pulse is registered.
module dictr_cmd_parser
    import dictr_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_data_rdy,
    output logic       det_S,
    output logic       det_cr,
    output logic       ld_valid,
    output logic [3:0] ld_Mtens,
    output logic [3:0] ld_Mones,
    output logic [3:0] ld_Stens,
    output logic [3:0] ld_Sones,
    output logic       parse_err,
    output logic       busy
);

    parser_state_t state, state_next;
    logic [23:0]   idle_cnt;
    logic [3:0]    dig_mt, dig_mo, dig_st, dig_so;
    logic [3:0]    mt_next, mo_next, st_next, so_next;
    logic          det_s_next, det_cr_next, ld_valid_next, parse_err_next;
    logic [3:0]    bcd;
    logic          in_range;
    logic          timeout;

    dictr_digit_check u_digit_check (
        .ascii     (rx_data),
        .max_digit (max_digit_for(state)),
        .bcd       (bcd),
        .in_range  (in_range)
    );

    assign busy = (state != IDLE);

    // A byte arriving in the timeout cycle wins; the timeout is dropped.
    assign timeout = busy && !rx_data_rdy && (idle_cnt == TIMEOUT_CYC - 24'd1);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
        state_next     = state;
        det_s_next     = 1'b0;
        det_cr_next    = 1'b0;
        ld_valid_next  = 1'b0;
        parse_err_next = 1'b0;
        mt_next        = dig_mt;
        mo_next        = dig_mo;
        st_next        = dig_st;
        so_next        = dig_so;

        if (rx_data_rdy) begin
            unique case (state)
                IDLE: begin
                    if (rx_data == ASCII_S_UP || rx_data == ASCII_S_LO)
                        det_s_next = 1'b1;
                    else if (rx_data == ASCII_CR)
                        det_cr_next = 1'b1;
                    else if (rx_data == ASCII_L_UP || rx_data == ASCII_L_LO)
                        state_next = GET_MT;
                end
                GET_MT, GET_MO, GET_ST, GET_SO: begin
                    if (rx_data == ASCII_ESC) begin
                        state_next = IDLE;
                    end else if (in_range) begin
                        unique case (state)
                            GET_MT:  begin mt_next = bcd; state_next = GET_MO;  end
                            GET_MO:  begin mo_next = bcd; state_next = GET_ST;  end
                            GET_ST:  begin st_next = bcd; state_next = GET_SO;  end
                            default: begin so_next = bcd; state_next = WAIT_CR; end
                        endcase
                    end else begin
                        parse_err_next = 1'b1;
                        state_next     = IDLE;
                    end
                end
                WAIT_CR: begin
                    state_next = IDLE;
                    if (rx_data == ASCII_CR)
                        ld_valid_next = 1'b1;
                    else if (rx_data != ASCII_ESC)
                        parse_err_next = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end else if (timeout) begin
            parse_err_next = 1'b1;
            state_next     = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            det_S     <= 1'b0;
            det_cr    <= 1'b0;
            ld_valid  <= 1'b0;
            parse_err <= 1'b0;
            dig_mt    <= 4'd0;
            dig_mo    <= 4'd0;
            dig_st    <= 4'd0;
            dig_so    <= 4'd0;
            ld_Mtens  <= 4'd0;
            ld_Mones  <= 4'd0;
            ld_Stens  <= 4'd0;
            ld_Sones  <= 4'd0;
        end else begin
            state     <= state_next;
            det_S     <= det_s_next;
            det_cr    <= det_cr_next;
            ld_valid  <= ld_valid_next;
            parse_err <= parse_err_next;
            dig_mt    <= mt_next;
            dig_mo    <= mo_next;
            dig_st    <= st_next;
            dig_so    <= so_next;
            // Outputs only change on a completed load, so partial digits never leak.
            if (ld_valid_next) begin
                ld_Mtens <= mt_next;
                ld_Mones <= mo_next;
                ld_Stens <= st_next;
                ld_Sones <= so_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rx_data_rdy || !busy)
            idle_cnt <= 24'd0;
        else
            idle_cnt <= idle_cnt + 24'd1;
    end

endmodule

// File: tb/tb_dictr_cmd_parser.sv
// Directed bench for dictr_cmd_parser with a short timeout; inputs are driven
// and outputs sampled on the falling clock edge.
module tb_dictr_cmd_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       det_S, det_cr, ld_valid, parse_err, busy;
    logic [3:0] ld_Mtens, ld_Mones, ld_Stens, ld_Sones;

    int n_vec = 0;
    int n_err = 0;

    dictr_cmd_parser #(.TIMEOUT_CYC(24'd16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .det_S       (det_S),
        .det_cr      (det_cr),
        .ld_valid    (ld_valid),
        .ld_Mtens    (ld_Mtens),
        .ld_Mones    (ld_Mones),
        .ld_Stens    (ld_Stens),
        .ld_Sones    (ld_Sones),
        .parse_err   (parse_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // {det_S, det_cr, ld_valid, parse_err}
    function automatic logic [3:0] pulses();
        return {det_S, det_cr, ld_valid, parse_err};
    endfunction

    function automatic logic [15:0] ld_word();
        return {ld_Mtens, ld_Mones, ld_Stens, ld_Sones};
    endfunction

    // Called at a falling edge; returns at the next falling edge, when the
    // registered response to the byte is visible.
    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        rx_data_rdy = 1'b1;
        @(negedge clk);
        rx_data_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({pulses(), busy, ld_word()} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", {pulses(), busy, ld_word()});
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({pulses(), busy} !== 5'd0) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b want 00000", {pulses(), busy});
        end
    endtask

    task automatic test_start_stop();
        logic [7:0] bytes [3] = '{8'h73, 8'h53, 8'h0D};
        logic [3:0] want  [3] = '{4'b1000, 4'b1000, 4'b0100};
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (pulses() !== 4'b0000) begin
                n_err++;
                $display("FAIL pre_strobe_%0d: got %b want 0000", i, pulses());
            end
            send_byte(bytes[i]);
            n_vec++;
            if ({pulses(), busy} !== {want[i], 1'b0}) begin
                n_err++;
                $display("FAIL cmd_pulse_%0d: got %b want %b", i, {pulses(), busy}, {want[i], 1'b0});
            end
            @(negedge clk);
            n_vec++;
            if (pulses() !== 4'b0000) begin
                n_err++;
                $display("FAIL cmd_pulse_width_%0d: got %b want 0000", i, pulses());
            end
        end
        send_byte(8'h41);
        n_vec++;
        if ({pulses(), busy} !== 5'd0) begin
            n_err++;
            $display("FAIL idle_ignore: got %b want 00000", {pulses(), busy});
        end
    endtask

    task automatic test_load();
        logic [7:0] seq [5] = '{8'h4C, 8'h31, 8'h32, 8'h33, 8'h34};
        for (int i = 0; i < 5; i++) begin
            send_byte(seq[i]);
            n_vec++;
            if ({pulses(), busy, ld_word()} !== {5'b00001, 16'h0000}) begin
                n_err++;
                $display("FAIL load_step_%0d: got %h want %h", i, {pulses(), busy, ld_word()},
                         {5'b00001, 16'h0000});
            end
        end
        send_byte(8'h0D);
        n_vec++;
        if ({pulses(), ld_word()} !== {4'b0010, 16'h1234}) begin
            n_err++;
            $display("FAIL load_valid: got %h want %h", {pulses(), ld_word()}, {4'b0010, 16'h1234});
        end
        @(negedge clk);
        n_vec++;
        if ({pulses(), busy, ld_word()} !== {5'b00000, 16'h1234}) begin
            n_err++;
            $display("FAIL load_after: got %h want %h", {pulses(), busy, ld_word()}, {5'b00000, 16'h1234});
        end
    endtask

    task automatic test_bad_digit();
        send_byte(8'h6C);
        send_byte(8'h36);
        n_vec++;
        if ({pulses(), busy, ld_word()} !== {5'b00010, 16'h1234}) begin
            n_err++;
            $display("FAIL bad_digit: got %h want %h", {pulses(), busy, ld_word()}, {5'b00010, 16'h1234});
        end
        @(negedge clk);
        n_vec++;
        if (pulses() !== 4'b0000) begin
            n_err++;
            $display("FAIL bad_digit_width: got %b want 0000", pulses());
        end
        // Early CR in GET_MO is an error, not a stop command.
        send_byte(8'h4C);
        send_byte(8'h31);
        send_byte(8'h0D);
        n_vec++;
        if ({pulses(), busy, ld_word()} !== {5'b00010, 16'h1234}) begin
            n_err++;
            $display("FAIL early_cr: got %h want %h", {pulses(), busy, ld_word()}, {5'b00010, 16'h1234});
        end
        // Any non-CR byte in WAIT_CR is rejected.
        send_byte(8'h4C); send_byte(8'h35); send_byte(8'h39); send_byte(8'h35); send_byte(8'h39);
        send_byte(8'h53);
        n_vec++;
        if ({pulses(), busy, ld_word()} !== {5'b00010, 16'h1234}) begin
            n_err++;
            $display("FAIL wait_cr_reject: got %h want %h", {pulses(), busy, ld_word()}, {5'b00010, 16'h1234});
        end
    endtask

    task automatic test_timeout();
        logic fired_early = 1'b0;
        send_byte(8'h4C);
        send_byte(8'h31);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (parse_err !== 1'b0 || busy !== 1'b1) fired_early = 1'b1;
        end
        n_vec++;
        if (fired_early !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_early: got early err/idle want none");
        end
        @(negedge clk);
        n_vec++;
        if ({pulses(), busy} !== 5'b00010) begin
            n_err++;
            $display("FAIL timeout_pulse: got %b want 00010", {pulses(), busy});
        end
        @(negedge clk);
        send_byte(8'h53);
        n_vec++;
        if (pulses() !== 4'b1000) begin
            n_err++;
            $display("FAIL timeout_then_s: got %b want 1000", pulses());
        end
        // Byte landing on the timeout cycle is processed; no error.
        send_byte(8'h4C);
        repeat (15) @(negedge clk);
        send_byte(8'h32);
        n_vec++;
        if ({pulses(), busy} !== 5'b00001) begin
            n_err++;
            $display("FAIL timeout_collide: got %b want 00001", {pulses(), busy});
        end
        send_byte(8'h1B);
    endtask

    task automatic test_escape();
        logic [7:0] seq [4] = '{8'h4C, 8'h30, 8'h35, 8'h1B};
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i]);
            n_vec++;
            if ({pulses(), busy} !== {4'b0000, (i < 3)}) begin
                n_err++;
                $display("FAIL escape_step_%0d: got %b want %b", i, {pulses(), busy}, {4'b0000, (i < 3)});
            end
        end
        @(negedge clk);
        n_vec++;
        if ({pulses(), busy, ld_word()} !== {5'b00000, 16'h1234}) begin
            n_err++;
            $display("FAIL escape_after: got %h want %h", {pulses(), busy, ld_word()}, {5'b00000, 16'h1234});
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h4C);
        send_byte(8'h30);
        send_byte(8'h35);
        // Strobe coincides with reset; reset must win.
        rst         = 1'b1;
        rx_data     = 8'h53;
        rx_data_rdy = 1'b1;
        @(negedge clk);
        rx_data_rdy = 1'b0;
        rst         = 1'b0;
        n_vec++;
        if ({pulses(), busy, ld_word()} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_mid: got %h want 0", {pulses(), busy, ld_word()});
        end
        @(negedge clk);
        n_vec++;
        if ({pulses(), busy} !== 5'd0) begin
            n_err++;
            $display("FAIL reset_mid_quiet: got %b want 00000", {pulses(), busy});
        end
        send_byte(8'h53);
        n_vec++;
        if ({pulses(), busy} !== 5'b10000) begin
            n_err++;
            $display("FAIL reset_then_s: got %b want 10000", {pulses(), busy});
        end
    endtask

    initial begin
        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_data_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_start_stop();
        test_load();
        test_bad_digit();
        test_timeout();
        test_escape();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
